// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the 32x32 register file write port, with
// youngest-value forwarding lookups. Define RF_WB_COALESCE_EN to merge back-to-back writes to the same rd.
module rf_writeback_queue #(
  parameter int unsigned n     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [4:0]               wb_rd,
  input  logic [n-1:0]             wb_data,
  input  logic                     drain_en,
  output logic                     regWrite,
  output logic [4:0]               writeReg,
  output logic [n-1:0]             writeData,
  input  logic [4:0]               readReg1,
  input  logic [4:0]               readReg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [n-1:0]             fwd_data1,
  output logic [n-1:0]             fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [4:0]       rd_q   [DEPTH];
  logic [n-1:0]     data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_idx, fidx;
  logic             not_empty, full, drain, ready, accept, enq, coal;
`ifdef RF_WB_COALESCE_EN
  logic [PTR_W-1:0] youngest;
`endif

  // Handshake, drain and pointer/count next-state
  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == CNT_W'(DEPTH));
    drain     = !rst && not_empty && drain_en;
`ifdef RF_WB_COALESCE_EN
    youngest  = tail_q - PTR_W'(1);
    // The youngest entry cannot absorb a write while it is leaving as head.
    coal      = not_empty && (rd_q[youngest] == wb_rd) &&
                !(drain && (count_q == CNT_W'(1)));
    ready     = !rst && (!full || coal);
    wr_idx    = coal ? youngest : tail_q;
`else
    coal      = 1'b0;
    ready     = !rst && !full;
    wr_idx    = tail_q;
`endif
    accept    = wb_valid && ready && (wb_rd != 5'd0);
    enq       = accept && !coal;
    head_d    = head_q + PTR_W'(drain);
    tail_d    = tail_q + PTR_W'(enq);
    count_d   = count_q + CNT_W'(enq) - CNT_W'(drain);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q[wr_idx]   <= wb_rd;
      data_q[wr_idx] <= wb_data;
    end
  end

  // Forwarding: scan oldest to youngest so the last match wins
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    fidx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fidx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((readReg1 != 5'd0) && (rd_q[fidx] == readReg1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[fidx];
        end
        if ((readReg2 != 5'd0) && (rd_q[fidx] == readReg2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[fidx];
        end
      end
    end
    if (rst) begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
    end
  end

  assign wb_ready  = ready;
  assign regWrite  = drain;
  assign writeReg  = rd_q[head_q];
  assign writeData = data_q[head_q];
  assign count     = count_q;
  assign empty     = rst || !not_empty;

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side initiator for the 32x32 register file.
- Buffers retiring writeback results from the pipeline in an in-order FIFO and drains them one per cycle onto the register file write port.
- Provides forwarding lookups so decode reads return the youngest value still pending in the queue.
- Sits between the writeback stage and the register file write port (`writeReg`, `regWrite`, `writeData`).

Parameters:
- n, 32, data width of each register value
- DEPTH, 4, number of queue entries; power of 2, minimum 2

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- wb_valid  input  1  writeback result offered
- wb_ready  output  1  queue can accept an entry this cycle
- wb_rd  input  5  destination register index
- wb_data  input  n  destination value
- drain_en  input  1  register file write port available this cycle
- regWrite  output  1  write strobe to register file
- writeReg  output  5  write index to register file
- writeData  output  n  write data to register file
- readReg1  input  5  decode source index 1 for forwarding lookup
- readReg2  input  5  decode source index 2 for forwarding lookup
- fwd_hit1  output  1  pending write to readReg1 exists
- fwd_hit2  output  1  pending write to readReg2 exists
- fwd_data1  output  n  youngest pending value for readReg1
- fwd_data2  output  n  youngest pending value for readReg2
- count  output  $clog2(DEPTH)+1  number of valid entries
- empty  output  1  count == 0

Behaviour:
- Storage: circular buffer with head pointer, tail pointer and count, all registered. Pointers wrap modulo DEPTH.
- Accept: a handshake occurs when `wb_valid && wb_ready`.
  - `wb_ready = !full`, with full meaning count == DEPTH.
  - No same-cycle pass-through, so `wb_ready` stays 0 while full even if a drain occurs that cycle.
- x0 filtering: a handshake with `wb_rd == 0` is accepted and discarded. No entry is written and count is unchanged.
- Drain outputs: combinational from the head entry only, never from the `wb_*` inputs.
  - `regWrite = !empty && drain_en`
  - `writeReg = head.rd`, `writeData = head.data`
  - When `regWrite` is 0, `writeReg` and `writeData` are don't-care.
  - On a cycle with `regWrite` = 1, head advances by 1 at the clock edge.
- Latency: an entry accepted at edge k is presented on `regWrite` no earlier than cycle k+1.
- Ordering: strictly in-order. Entry values are never reordered or merged, except as described under Optional Feature.
- Count update: count increments on an enqueue, decrements on a drain, and is unchanged when both occur in the same cycle.
  - Simultaneous enqueue and drain at count == DEPTH cannot happen, because `wb_ready` is 0 when full.
  - At count == 1 with simultaneous enqueue and drain, the new entry becomes head next cycle.
- Forwarding, per port, combinational:
  - Searches all valid entries, including the head being drained this cycle, for `rd == readRegX`.
  - The hit returns the youngest matching entry, i.e. the one closest to tail.
  - `readRegX == 0` never hits; `fwd_dataX` is 0 on a miss.
  - The incoming `wb_*` of the current cycle is not searched.
- Reset, synchronous:
  - head, tail and count are cleared to 0.
  - While `rst` is high: `wb_ready` = 0, `regWrite` = 0, `fwd_hit1/2` = 0, `empty` = 1.
  - Reset mid-operation discards all pending entries with no further `regWrite`. Entry data registers need not be cleared.
  - First acceptance is possible in the cycle after `rst` deasserts.

Optional Feature:
- Macro: RF_WB_COALESCE_EN
- Defined: an accepted write whose `wb_rd` equals the rd of the youngest valid entry overwrites that entry's data in place, with count and tail unchanged.
  - This applies only when that entry is not simultaneously being drained (`regWrite` = 1 with count == 1).
  - It also applies when the queue is full, so `wb_ready` is 1 when full and `wb_rd` matches the youngest entry's rd (and that entry is not simultaneously being drained).
- Not defined: every non-x0 accepted write allocates a new entry. No comparator on the enqueue path.

Test Plan:
1. Fill and drain: `drain_en` = 0, enqueue (rd=5,0x11), (rd=6,0x22), (rd=7,0x33), (rd=8,0x44).
   - count=4, `wb_ready`=0.
   - Then `drain_en`=1: `regWrite` pulses for 4 consecutive cycles with writeReg 5,6,7,8 and data 0x11..0x44, then `empty`=1.
2. x0 drop: enqueue (rd=0,0xDEAD) -> handshake completes, count stays 0, `regWrite` never asserts.
3. Forwarding: `drain_en`=0, enqueue (rd=3,0xA), (rd=3,0xB), (rd=4,0xC).
   - `readReg1`=3 -> `fwd_hit1`=1, `fwd_data1`=0xB.
   - `readReg2`=9 -> `fwd_hit2`=0, `fwd_data2`=0.
   - `readReg1`=0 -> `fwd_hit1`=0.
4. Simultaneous enqueue and drain: steady `wb_valid`=1 and `drain_en`=1 for 20 cycles with incrementing rd/data.
   - count holds at 1 after the first cycle.
   - `regWrite` sequence equals the input sequence, delayed by 1 cycle.
5. Reset mid-operation: 3 entries pending, assert `rst` for 1 cycle.
   - `regWrite`=0 and count=0 the following cycle, no stale writes afterward.
   - `wb_ready`=1 the cycle after deassert.
6. RF_WB_COALESCE_EN: `drain_en`=0, enqueue (rd=2,0x1) then (rd=2,0x2).
   - With the macro defined: count=1, and the drain emits a single write (2,0x2).
   - Without the macro: count=2, and the drain emits (2,0x1) then (2,0x2).
